// File: rtl/mem_req_ctrl.sv
// MEM-stage request controller: issues one cache access per instruction tag,
// stalls until completion or timeout, and keeps sticky error flags.
module mem_req_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TAG_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TAG_W-1:0]  instr_tag,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  output logic              err_illegal,
  output logic              cache_rd,
  output logic              cache_wr,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_done,
  input  logic              cache_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]        state_reg;
  logic              op_rd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [TAG_W-1:0]  last_tag_reg;
  logic              tag_vld_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              err_illegal_reg;

  logic in_idle, in_busy, tag_new, issue, illegal_req, done_seen, timed_out;
  logic err_set;

  assign in_idle     = (state_reg == IDLE);
  assign in_busy     = (state_reg == BUSY);
  assign tag_new     = !tag_vld_reg || (instr_tag != last_tag_reg);
  // Gate on rst so no strobe or stall escapes while reset is held.
  assign issue       = rst && in_idle && (mem_read ^ mem_write) && tag_new;
  assign illegal_req = in_idle && mem_read && mem_write && tag_new;
  assign done_seen   = in_busy && cache_done;
  assign timed_out   = in_busy && !cache_done && (cnt_reg == CNT_LAST);
  assign err_set     = (done_seen && cache_err) || timed_out;

  assign cache_rd    = issue && mem_read;
  assign cache_wr    = issue && mem_write;
  assign stall       = issue || in_busy;
  assign cache_addr  = in_busy ? addr_reg  : addr;
  assign cache_wdata = in_busy ? wdata_reg : wdata;

  assign rdata       = rdata_reg;
  assign err         = err_reg;
  assign err_illegal = err_illegal_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      op_rd_reg       <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      last_tag_reg    <= '0;
      tag_vld_reg     <= 1'b0;
      cnt_reg         <= '0;
      rdata_reg       <= '0;
      err_reg         <= 1'b0;
      err_illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (issue) begin
            state_reg    <= BUSY;
            op_rd_reg    <= mem_read;
            addr_reg     <= addr;
            wdata_reg    <= wdata;
            last_tag_reg <= instr_tag;
            tag_vld_reg  <= 1'b1;
            cnt_reg      <= '0;
          end else if (illegal_req) begin
            last_tag_reg <= instr_tag;
            tag_vld_reg  <= 1'b1;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (done_seen) begin
            if (op_rd_reg) rdata_reg <= cache_rdata;
            state_reg <= IDLE;
          end else if (timed_out) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A set event in the same cycle as err_clr keeps the flag high.
      if (err_set)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;

      if (illegal_req)  err_illegal_reg <= 1'b1;
      else if (err_clr) err_illegal_reg <= 1'b0;
    end
  end

endmodule
